// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - prefix constants, immediate classes and opcode tables for length decode
package decode_pkg;

   localparam int PKT_W   = 128;
   localparam int MAX_PFX = 4;

   localparam logic [7:0] PFX_ES     = 8'h26;
   localparam logic [7:0] PFX_CS     = 8'h2E;
   localparam logic [7:0] PFX_SS     = 8'h36;
   localparam logic [7:0] PFX_DS     = 8'h3E;
   localparam logic [7:0] PFX_FS     = 8'h64;
   localparam logic [7:0] PFX_GS     = 8'h65;
   localparam logic [7:0] PFX_OPSIZE = 8'h66;
   localparam logic [7:0] PFX_LOCK   = 8'hF0;
   localparam logic [7:0] PFX_REPNE  = 8'hF2;
   localparam logic [7:0] PFX_REP    = 8'hF3;
   localparam logic [7:0] OPC_ESC    = 8'h0F;

   typedef enum logic [2:0] {
      IMM_NONE,
      IMM_I8,
      IMM_I16,
      IMM_IOS,
      IMM_I16_I8,
      IMM_PTR
   } imm_class_e;

   function automatic logic is_prefix(input logic [7:0] b);
      return b inside {PFX_ES, PFX_CS, PFX_SS, PFX_DS, PFX_FS, PFX_GS,
                       PFX_OPSIZE, PFX_LOCK, PFX_REPNE, PFX_REP};
   endfunction

   function automatic logic one_byte_modrm(input logic [7:0] op);
      return (op < 8'h40 && !op[2]) ||
             (op inside {8'h62, 8'h63, 8'h69, 8'h6B, [8'h80:8'h8F], 8'hC0, 8'hC1,
                         [8'hC4:8'hC7], [8'hD0:8'hD3], [8'hD8:8'hDF],
                         8'hF6, 8'hF7, 8'hFE, 8'hFF});
   endfunction

   function automatic logic two_byte_modrm(input logic [7:0] op);
      return op inside {[8'h00:8'h03], [8'h10:8'h7F], [8'h90:8'h9F], 8'hA3, 8'hA4,
                        8'hA5, 8'hAB, 8'hAC, 8'hAD, 8'hAF, [8'hB0:8'hB7],
                        [8'hBA:8'hBF], [8'hC0:8'hC7]};
   endfunction

   function automatic imm_class_e one_byte_imm(input logic [7:0] op);
      imm_class_e c;
      c = IMM_NONE;
      // ALU block 00-3F: xx4 is AL,imm8 and xx5 is eAX,imm
      if (op < 8'h40 && op[2:0] == 3'd4)
         c = IMM_I8;
      else if (op < 8'h40 && op[2:0] == 3'd5)
         c = IMM_IOS;
      else if (op inside {8'h6A, 8'h6B, 8'h80, 8'h82, 8'h83, 8'hA8, 8'hC0, 8'hC1, 8'hC6,
                          8'hCD, 8'hD4, 8'hD5, 8'hEB, 8'hF6, [8'h70:8'h7F],
                          [8'hB0:8'hB7], [8'hE0:8'hE7]})
         c = IMM_I8;
      else if (op inside {8'h68, 8'h69, 8'h81, 8'hA9, 8'hC7, 8'hE8, 8'hE9, 8'hF7,
                          [8'hB8:8'hBF]})
         c = IMM_IOS;
      else if (op inside {8'hC2, 8'hCA})
         c = IMM_I16;
      else if (op == 8'hC8)
         c = IMM_I16_I8;
      else if (op inside {8'h9A, 8'hEA})
         c = IMM_PTR;
      return c;
   endfunction

   function automatic imm_class_e two_byte_imm(input logic [7:0] op);
      imm_class_e c;
      c = IMM_NONE;
      if (op inside {[8'h70:8'h73], 8'hA4, 8'hAC, 8'hBA, 8'hC2, [8'hC4:8'hC6]})
         c = IMM_I8;
      else if (op inside {[8'h80:8'h8F]})
         c = IMM_IOS;
      return c;
   endfunction

   // Tables indexed by {two_byte, opcode}
   function automatic logic [511:0] build_modrm_tbl();
      logic [511:0] t;
      t = '0;
      for (int i = 0; i < 256; i++) begin
         t[i]       = one_byte_modrm(8'(i));
         t[256 + i] = two_byte_modrm(8'(i));
      end
      return t;
   endfunction

   function automatic logic [1535:0] build_imm_tbl();
      logic [1535:0] t;
      t = '0;
      for (int i = 0; i < 256; i++) begin
         t[3*i +: 3]         = one_byte_imm(8'(i));
         t[3*(256 + i) +: 3] = two_byte_imm(8'(i));
      end
      return t;
   endfunction

   localparam logic [511:0]  MODRM_TBL = build_modrm_tbl();
   localparam logic [1535:0] IMM_TBL   = build_imm_tbl();

   function automatic imm_class_e imm_lookup(input logic [8:0] idx);
      return imm_class_e'(IMM_TBL[int'(idx)*3 +: 3]);
   endfunction

   function automatic logic [3:0] imm_bytes(input imm_class_e c, input logic os16);
      logic [3:0] n;
      case (c)
         IMM_I8:     n = 4'd1;
         IMM_I16:    n = 4'd2;
         IMM_IOS:    n = os16 ? 4'd2 : 4'd4;
         IMM_I16_I8: n = 4'd3;
         IMM_PTR:    n = os16 ? 4'd4 : 4'd6;
         default:    n = 4'd0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/length_decoder.sv
// rtl/length_decoder.sv - combinational 32-bit-address x86 length decode of one fetch packet
module length_decoder
   import decode_pkg::*;
#(
   parameter int PW   = PKT_W,
   parameter int MAXP = MAX_PFX
) (
   input  logic [PW-1:0] i_packet,
   input  logic          i_valid,
   output logic [7:0]    o_length,
   output logic [2:0]    o_pfx_cnt,
   output logic [3:0]    o_opc_ofs,
   output logic [3:0]    o_modrm_ofs,
   output logic          o_opsize16,
   output logic          o_illegal
);

   function automatic logic [7:0] pkt_byte(input logic [PW-1:0] p, input logic [3:0] idx);
      return p[{idx, 3'b000} +: 8];
   endfunction

   logic [2:0] w_cnt;
   logic       w_done;
   logic       w_opsize16;
   logic       w_illegal;
   logic [3:0] w_opc_pos;
   logic       w_esc;
   logic [7:0] w_op;
   logic [3:0] w_opc_len;
   logic [8:0] w_tbl_idx;
   logic       w_has_modrm;
   logic [3:0] w_modrm_pos;
   logic [7:0] w_modrm;
   logic [2:0] w_sib_base;
   logic       w_has_sib;
   logic [3:0] w_disp_len;
   logic [3:0] w_imm_len;
   logic [7:0] w_sum;

   always_comb begin
      w_cnt      = '0;
      w_done     = 1'b0;
      w_opsize16 = 1'b0;
      // Only MAXP+1 bytes need scanning: one prefix beyond the limit already makes it illegal
      for (int i = 0; i <= MAXP; i++) begin
         if (!w_done && is_prefix(pkt_byte(i_packet, 4'(i)))) begin
            w_cnt = w_cnt + 3'd1;
            if (pkt_byte(i_packet, 4'(i)) == PFX_OPSIZE)
               w_opsize16 = 1'b1;
         end else begin
            w_done = 1'b1;
         end
      end

      w_illegal   = int'(w_cnt) > MAXP;
      w_opc_pos   = {1'b0, w_cnt};
      w_esc       = pkt_byte(i_packet, w_opc_pos) == OPC_ESC;
      w_op        = w_esc ? pkt_byte(i_packet, w_opc_pos + 4'd1) : pkt_byte(i_packet, w_opc_pos);
      w_opc_len   = w_esc ? 4'd2 : 4'd1;
      w_tbl_idx   = {w_esc, w_op};
      w_has_modrm = MODRM_TBL[w_tbl_idx];
      w_modrm_pos = w_opc_pos + w_opc_len;
      w_modrm     = pkt_byte(i_packet, w_modrm_pos);
      w_sib_base  = i_packet[{w_modrm_pos + 4'd1, 3'b000} +: 3];
      w_has_sib   = w_has_modrm && (w_modrm[7:6] != 2'b11) && (w_modrm[2:0] == 3'b100);

      w_disp_len = 4'd0;
      if (w_has_modrm) begin
         case (w_modrm[7:6])
            2'b01:   w_disp_len = 4'd1;
            2'b10:   w_disp_len = 4'd4;
            2'b00:   if (w_modrm[2:0] == 3'b101 || (w_has_sib && w_sib_base == 3'b101))
                        w_disp_len = 4'd4;
            default: w_disp_len = 4'd0;
         endcase
      end

      w_imm_len = imm_bytes(imm_lookup(w_tbl_idx), w_opsize16);
      // Group-3: only TEST (reg=000) carries an immediate
      if (!w_esc && (w_op == 8'hF6 || w_op == 8'hF7) && w_modrm[5:3] != 3'b000)
         w_imm_len = 4'd0;

      w_sum = 8'(w_opc_pos) + 8'(w_opc_len) + 8'(w_has_modrm) + 8'(w_has_sib)
            + 8'(w_disp_len) + 8'(w_imm_len);

      if (!i_valid)
         o_length = 8'd0;
      else if (w_illegal)
         o_length = 8'(MAXP + 1);
      else
         o_length = w_sum;

      o_pfx_cnt   = w_cnt;
      o_opc_ofs   = w_opc_pos;
      o_modrm_ofs = w_has_modrm ? w_modrm_pos : 4'd0;
      o_opsize16  = w_opsize16;
      o_illegal   = i_valid && w_illegal;
   end

endmodule

// File: rtl/decode_length_stage.sv
// rtl/decode_length_stage.sv - D1 length decode feeding fetch, plus the D1->D2 pipeline register
module decode_length_stage #(
   parameter int PKT_W   = 128,
   parameter int MAX_PFX = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [PKT_W-1:0] packet_in,
   input  logic             packet_valid_in,
   input  logic             is_BR_T_NT_in,
   input  logic [31:0]      BP_target_in,
   input  logic [5:0]       BP_update_alias_in,
   input  logic             IE_in,
   input  logic [3:0]       IE_type_in,
   input  logic             instr_is_IDTR_orig_in,
   input  logic             IDTR_is_POP_EFLAGS_in,
   input  logic             resteer,
   input  logic             d2_stall,
   output logic [7:0]       D_length,
   output logic             stall,
   output logic             d2_valid,
   output logic [PKT_W-1:0] d2_packet,
   output logic [7:0]       d2_length,
   output logic [2:0]       d2_pfx_cnt,
   output logic [3:0]       d2_opc_ofs,
   output logic [3:0]       d2_modrm_ofs,
   output logic             d2_opsize16,
   output logic             d2_is_BR_T_NT,
   output logic [31:0]      d2_BP_target,
   output logic [5:0]       d2_BP_update_alias,
   output logic             d2_IE,
   output logic [3:0]       d2_IE_type,
   output logic             d2_instr_is_IDTR,
   output logic             d2_IDTR_is_POP_EFLAGS
);

   logic [7:0] w_length;
   logic [2:0] w_pfx_cnt;
   logic [3:0] w_opc_ofs;
   logic [3:0] w_modrm_ofs;
   logic       w_opsize16;
   logic       w_illegal;
   logic       w_stall;

   logic             r_valid;
   logic [PKT_W-1:0] r_packet;
   logic [7:0]       r_length;
   logic [2:0]       r_pfx_cnt;
   logic [3:0]       r_opc_ofs;
   logic [3:0]       r_modrm_ofs;
   logic             r_opsize16;
   logic             r_is_br;
   logic [31:0]      r_bp_target;
   logic [5:0]       r_bp_alias;
   logic             r_ie;
   logic [3:0]       r_ie_type;
   logic             r_idtr;
   logic             r_idtr_pop;

   length_decoder #(
      .PW   (PKT_W),
      .MAXP (MAX_PFX)
   ) u_length_decoder (
      .i_packet    (packet_in),
      .i_valid     (packet_valid_in),
      .o_length    (w_length),
      .o_pfx_cnt   (w_pfx_cnt),
      .o_opc_ofs   (w_opc_ofs),
      .o_modrm_ofs (w_modrm_ofs),
      .o_opsize16  (w_opsize16),
      .o_illegal   (w_illegal)
   );

   // An empty D2 register never back-pressures, so a bubble is always filled
   assign w_stall  = r_valid && d2_stall && !reset;
   assign stall    = w_stall;
   assign D_length = (w_stall || reset) ? 8'd0 : w_length;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid     <= 1'b0;
         r_packet    <= '0;
         r_length    <= '0;
         r_pfx_cnt   <= '0;
         r_opc_ofs   <= '0;
         r_modrm_ofs <= '0;
         r_opsize16  <= 1'b0;
         r_is_br     <= 1'b0;
         r_bp_target <= '0;
         r_bp_alias  <= '0;
         r_ie        <= 1'b0;
         r_ie_type   <= '0;
         r_idtr      <= 1'b0;
         r_idtr_pop  <= 1'b0;
      end else begin
         if (!w_stall) begin
            r_valid     <= packet_valid_in;
            r_packet    <= packet_in;
            r_length    <= w_length;
            r_pfx_cnt   <= w_pfx_cnt;
            r_opc_ofs   <= w_opc_ofs;
            r_modrm_ofs <= w_modrm_ofs;
            r_opsize16  <= w_opsize16;
            r_is_br     <= is_BR_T_NT_in;
            r_bp_target <= BP_target_in;
            r_bp_alias  <= BP_update_alias_in;
            r_ie        <= IE_in || w_illegal;
            r_ie_type   <= IE_type_in | {1'b0, w_illegal, 2'b00};
            r_idtr      <= instr_is_IDTR_orig_in;
            r_idtr_pop  <= IDTR_is_POP_EFLAGS_in;
         end
         if (resteer)
            r_valid <= 1'b0;
      end
   end

   assign d2_valid              = r_valid;
   assign d2_packet             = r_packet;
   assign d2_length             = r_length;
   assign d2_pfx_cnt            = r_pfx_cnt;
   assign d2_opc_ofs            = r_opc_ofs;
   assign d2_modrm_ofs          = r_modrm_ofs;
   assign d2_opsize16           = r_opsize16;
   assign d2_is_BR_T_NT         = r_is_br;
   assign d2_BP_target          = r_bp_target;
   assign d2_BP_update_alias    = r_bp_alias;
   assign d2_IE                 = r_ie;
   assign d2_IE_type            = r_ie_type;
   assign d2_instr_is_IDTR      = r_idtr;
   assign d2_IDTR_is_POP_EFLAGS = r_idtr_pop;

endmodule
